// File: rtl/posit_round_pipe.sv
// rtl/posit_round_pipe.sv - two-stage posit regime/exponent encode and round pipeline
// Optional inexact-beat counter port enabled by defining POSIT_ROUND_STATS_EN.
module posit_round_pipe #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int SW = $clog2(N) + ES + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic                 in_zero,
    input  logic                 in_nar,
    input  logic signed [SW-1:0] in_scale,
    input  logic [N-1:0]         in_frac,
    input  logic                 in_sticky,
    input  logic                 rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_posit,
    output logic                 out_inexact,
    output logic                 out_sat
`ifdef POSIT_ROUND_STATS_EN
    ,
    output logic [15:0]          stat_inexact_cnt
`endif
);

    localparam int KW = $clog2(N) + 1;
    localparam int EW = (ES > 0) ? ES : 1;
    localparam int BW = ES + N;
    localparam int TW = 2 * N + ES;
    localparam logic signed [SW-1:0] K_HI = SW'(N - 2);
    localparam logic signed [SW-1:0] K_LO = SW'(2 - N);

    logic                 s2_ready;

    logic                 s1_valid_q;
    logic                 s1_sign_q;
    logic                 s1_zero_q;
    logic                 s1_nar_q;
    logic [KW-1:0]        s1_k_q;
    logic [EW-1:0]        s1_e_q;
    logic [N-1:0]         s1_frac_q;
    logic                 s1_sticky_q;
    logic                 s1_rnd_q;
    logic                 s1_sat_q;

    logic signed [SW-1:0] k_full;
    logic [KW-1:0]        s1_k_d;
    logic                 s1_sat_d;
    logic [EW-1:0]        s1_e_d;

    logic                 out_valid_q;
    logic [N-1:0]         out_posit_q;
    logic                 out_inexact_q;
    logic                 out_sat_q;

    logic                 kneg;
    logic [KW-1:0]        shamt;
    logic [BW-1:0]        body;
    logic signed [TW-1:0] seed;
    logic [TW-1:0]        tword;
    logic [N-2:0]         kept;
    logic                 g_bit;
    logic                 s_bit;
    logic                 inc;
    logic [N-1:0]         rsum;
    logic                 rnd_ovf;
    logic                 rnd_unf;
    logic [N-1:0]         mag;
    logic [N-1:0]         out_posit_d;
    logic                 out_inexact_d;
    logic                 out_sat_d;

    assign s2_ready = ~out_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_ready;

    assign k_full = in_scale >>> ES;

    always_comb begin
        s1_k_d   = k_full[KW-1:0];
        s1_sat_d = 1'b0;
        if (k_full > K_HI) begin
            s1_k_d   = KW'(N - 2);
            s1_sat_d = 1'b1;
        end else if (k_full < K_LO) begin
            s1_k_d   = KW'(2 - N);
            s1_sat_d = 1'b1;
        end
    end

    generate
        if (ES > 0) begin : g_exp
            assign s1_e_d = in_scale[ES-1:0];
            assign body   = {s1_e_q, s1_frac_q};
        end else begin : g_noexp
            assign s1_e_d = 1'b0;
            assign body   = s1_frac_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            s1_k_q      <= '0;
            s1_e_q      <= '0;
            s1_frac_q   <= '0;
            s1_sticky_q <= 1'b0;
            s1_rnd_q    <= 1'b0;
            s1_sat_q    <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q   <= in_sign;
                s1_zero_q   <= in_zero;
                s1_nar_q    <= in_nar;
                s1_k_q      <= s1_k_d;
                s1_e_q      <= s1_e_d;
                s1_frac_q   <= in_frac;
                s1_sticky_q <= in_sticky;
                s1_rnd_q    <= rnd_mode;
                s1_sat_q    <= s1_sat_d;
            end
        end
    end

    // Seed "10" (k>=0) or "01" (k<0) and sign-fill shift: k>=0 shifts by k
    // (growing the ones run), k<0 shifts by -k-1 = ~k (growing the zeros run).
    assign kneg  = s1_k_q[KW-1];
    assign shamt = kneg ? ~s1_k_q : s1_k_q;
    assign seed  = {~kneg, kneg, body, {(N-2){1'b0}}};
    assign tword = seed >>> shamt;

    assign kept  = tword[TW-1 -: N-1];
    assign g_bit = tword[TW-N];
    assign s_bit = (|tword[TW-N-1:0]) | s1_sticky_q;
    assign inc   = ~s1_rnd_q & g_bit & (s_bit | kept[0]);
    assign rsum  = {1'b0, kept} + {{(N-1){1'b0}}, inc};

    assign rnd_ovf = rsum[N-1];
    assign rnd_unf = (rsum == '0);

    always_comb begin
        mag = rsum;
        if (rnd_ovf) begin
            mag = {1'b0, {(N-1){1'b1}}};
        end else if (rnd_unf) begin
            mag = {{(N-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        out_posit_d   = s1_sign_q ? (~mag + {{(N-1){1'b0}}, 1'b1}) : mag;
        out_inexact_d = g_bit | s_bit;
        out_sat_d     = s1_sat_q | rnd_ovf | rnd_unf;
        if (s1_nar_q) begin
            out_posit_d   = {1'b1, {(N-1){1'b0}}};
            out_inexact_d = 1'b0;
            out_sat_d     = 1'b0;
        end else if (s1_zero_q) begin
            out_posit_d   = '0;
            out_inexact_d = 1'b0;
            out_sat_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_posit_q   <= '0;
            out_inexact_q <= 1'b0;
            out_sat_q     <= 1'b0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_posit_q   <= out_posit_d;
                out_inexact_q <= out_inexact_d;
                out_sat_q     <= out_sat_d;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_posit   = out_posit_q;
    assign out_inexact = out_inexact_q;
    assign out_sat     = out_sat_q;

`ifdef POSIT_ROUND_STATS_EN
    logic [15:0] stat_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_q <= '0;
        end else if (out_valid_q && out_ready && out_inexact_q && (stat_cnt_q != 16'hFFFF)) begin
            stat_cnt_q <= stat_cnt_q + 16'd1;
        end
    end

    assign stat_inexact_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_posit_round_pipe.sv
// tb/tb_posit_round_pipe.sv - self-checking bench for posit_round_pipe (N=32, ES=2)
module tb_posit_round_pipe;

    localparam int N  = 32;
    localparam int ES = 2;
    localparam int SW = $clog2(N) + ES + 2;

    typedef struct {
        bit          sgn;
        bit          zro;
        bit          nr;
        int          scale;
        bit [31:0]   frac;
        bit          stk;
        bit          rnd;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_sign = 1'b0;
    logic                 in_zero = 1'b0;
    logic                 in_nar = 1'b0;
    logic signed [SW-1:0] in_scale = '0;
    logic [N-1:0]         in_frac = '0;
    logic                 in_sticky = 1'b0;
    logic                 rnd_mode = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [N-1:0]         out_posit;
    logic                 out_inexact;
    logic                 out_sat;
`ifdef POSIT_ROUND_STATS_EN
    logic [15:0]          stat_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    beat_t       dv_b[$];
    logic [31:0] dv_p[$];
    logic        dv_x[$];
    logic        dv_s[$];
    string       dv_n[$];

    posit_round_pipe #(.N(N), .ES(ES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_zero     (in_zero),
        .in_nar      (in_nar),
        .in_scale    (in_scale),
        .in_frac     (in_frac),
        .in_sticky   (in_sticky),
        .rnd_mode    (rnd_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_posit   (out_posit),
        .out_inexact (out_inexact),
        .out_sat     (out_sat)
`ifdef POSIT_ROUND_STATS_EN
        ,
        .stat_inexact_cnt (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: spell the posit out as a bit string, then round with integers.
    function automatic void model(input beat_t b, output logic [31:0] p, output logic inx, output logic sat);
        bit     q[$];
        int     k;
        int     e;
        longint m;
        longint maxm;
        bit     g;
        bit     s;
        p = '0; inx = 1'b0; sat = 1'b0;
        if (b.nr) begin
            p = 32'h8000_0000;
            return;
        end
        if (b.zro) return;
        k = b.scale >>> ES;
        e = b.scale & ((1 << ES) - 1);
        if (k > N - 2)    begin k = N - 2;    sat = 1'b1; end
        if (k < -(N - 2)) begin k = -(N - 2); sat = 1'b1; end
        if (k >= 0) begin
            for (int i = 0; i <= k; i++) q.push_back(1'b1);
            q.push_back(1'b0);
        end else begin
            for (int i = 0; i < -k; i++) q.push_back(1'b0);
            q.push_back(1'b1);
        end
        for (int i = ES - 1; i >= 0; i--) q.push_back(bit'((e >> i) & 1));
        for (int i = N - 1; i >= 0; i--) q.push_back(b.frac[i]);
        m = 0;
        for (int i = 0; i < N - 1; i++) m = m * 2 + longint'(q[i]);
        g = q[N-1];
        s = b.stk;
        for (int i = N; i < q.size(); i++) s = s | q[i];
        inx = g | s;
        if (!b.rnd && g && (s || (m % 2 == 1))) m = m + 1;
        maxm = (longint'(1) << (N - 1)) - 1;
        if (m > maxm) begin m = maxm; sat = 1'b1; end
        if (m == 0)   begin m = 1;    sat = 1'b1; end
        p = b.sgn ? 32'(-m) : 32'(m);
    endfunction

    function automatic beat_t mkb(input bit sg, input bit zr, input bit na, input int sc,
                                  input bit [31:0] fr, input bit st, input bit rn);
        beat_t b;
        b.sgn = sg; b.zro = zr; b.nr = na; b.scale = sc; b.frac = fr; b.stk = st; b.rnd = rn;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    r;
        r       = int'($urandom_range(0, 31));
        b.sgn   = bit'($urandom_range(0, 1));
        b.zro   = (r == 0);
        b.nr    = (r == 1);
        if ($urandom_range(0, 3) == 0) b.scale = int'($urandom_range(0, 511)) - 256;
        else                           b.scale = int'($urandom_range(0, 60)) - 30;
        if ($urandom_range(0, 3) == 0) b.frac = 32'($urandom_range(0, 255));
        else                           b.frac = $urandom;
        b.stk   = bit'($urandom_range(0, 1));
        b.rnd   = bit'($urandom_range(0, 1));
        return b;
    endfunction

    function automatic void add_vec(input string nm, input beat_t b, input logic [31:0] p,
                                    input logic x, input logic s);
        dv_n.push_back(nm); dv_b.push_back(b); dv_p.push_back(p); dv_x.push_back(x); dv_s.push_back(s);
    endfunction

    task automatic drive(input beat_t b);
        in_sign   = b.sgn;
        in_zero   = b.zro;
        in_nar    = b.nr;
        in_scale  = SW'(b.scale);
        in_frac   = b.frac;
        in_sticky = b.stk;
        rnd_mode  = b.rnd;
    endtask

    task automatic run_one(input beat_t b, output logic [31:0] p, output logic x, output logic s, output int lat);
        bit acc;
        acc = 1'b0; lat = -1; p = 'x; x = 1'bx; s = 1'bx;
        out_ready = 1'b1;
        @(negedge clk);
        drive(b);
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            #1 acc = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) return;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid) begin
                lat = c; p = out_posit; x = out_inexact; s = out_sat;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_posit !== '0 || out_inexact !== 1'b0 || out_sat !== 1'b0)
            $display("FAIL reset_outputs: got v=%b p=%h x=%b s=%b expected all zero",
                     out_valid, out_posit, out_inexact, out_sat);
        else n_pass++;
`ifdef POSIT_ROUND_STATS_EN
        n_checks++;
        if (stat_cnt !== 16'h0) $display("FAIL reset_stat: got %h expected 0000", stat_cnt);
        else n_pass++;
`endif
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] p;
        logic        x;
        logic        s;
        int          lat;
        add_vec("one",        mkb(1'b0, 1'b0, 1'b0,    0, 32'h0,        1'b0, 1'b0), 32'h4000_0000, 1'b0, 1'b0);
        add_vec("scale1",     mkb(1'b0, 1'b0, 1'b0,    1, 32'h0,        1'b0, 1'b0), 32'h4800_0000, 1'b0, 1'b0);
        add_vec("minus_one",  mkb(1'b1, 1'b0, 1'b0,    0, 32'h0,        1'b0, 1'b0), 32'hC000_0000, 1'b0, 1'b0);
        add_vec("rne_down",   mkb(1'b0, 1'b0, 1'b0,    0, 32'h10,       1'b0, 1'b0), 32'h4000_0000, 1'b1, 1'b0);
        add_vec("rne_up",     mkb(1'b0, 1'b0, 1'b0,    0, 32'h30,       1'b0, 1'b0), 32'h4000_0002, 1'b1, 1'b0);
        add_vec("rtz",        mkb(1'b0, 1'b0, 1'b0,    0, 32'h30,       1'b0, 1'b1), 32'h4000_0001, 1'b1, 1'b0);
        add_vec("rne_sticky", mkb(1'b0, 1'b0, 1'b0,    0, 32'h10,       1'b1, 1'b0), 32'h4000_0001, 1'b1, 1'b0);
        add_vec("maxpos",     mkb(1'b0, 1'b0, 1'b0,  200, 32'h0,        1'b0, 1'b0), 32'h7FFF_FFFF, 1'b0, 1'b1);
        add_vec("minpos",     mkb(1'b0, 1'b0, 1'b0, -200, 32'h0,        1'b0, 1'b0), 32'h0000_0001, 1'b0, 1'b1);
        add_vec("neg_maxpos", mkb(1'b1, 1'b0, 1'b0,  200, 32'h0,        1'b0, 1'b0), 32'h8000_0001, 1'b0, 1'b1);
        add_vec("k_lo_edge",  mkb(1'b0, 1'b0, 1'b0, -120, 32'h0,        1'b0, 1'b0), 32'h0000_0001, 1'b0, 1'b0);
        add_vec("k_hi_edge",  mkb(1'b0, 1'b0, 1'b0,  123, 32'h0,        1'b0, 1'b0), 32'h7FFF_FFFF, 1'b1, 1'b0);
        add_vec("k29_round",  mkb(1'b0, 1'b0, 1'b0,  119, 32'h0,        1'b0, 1'b0), 32'h7FFF_FFFF, 1'b1, 1'b0);
        add_vec("scale_m1",   mkb(1'b0, 1'b0, 1'b0,   -1, 32'h0,        1'b0, 1'b0), 32'h3800_0000, 1'b0, 1'b0);
        add_vec("zero",       mkb(1'b1, 1'b1, 1'b0,   17, 32'hFFFF_FFFF, 1'b1, 1'b0), 32'h0000_0000, 1'b0, 1'b0);
        add_vec("nar",        mkb(1'b0, 1'b0, 1'b1,  200, 32'h1234_5678, 1'b1, 1'b0), 32'h8000_0000, 1'b0, 1'b0);
        add_vec("zero_nar",   mkb(1'b1, 1'b1, 1'b1,    3, 32'hFFFF_FFFF, 1'b1, 1'b0), 32'h8000_0000, 1'b0, 1'b0);
        for (int i = 0; i < dv_b.size(); i++) begin
            run_one(dv_b[i], p, x, s, lat);
            n_checks++;
            if (lat !== 2) $display("FAIL %s_latency: got %0d expected 2", dv_n[i], lat);
            else n_pass++;
            n_checks++;
            if (p !== dv_p[i]) $display("FAIL %s_posit: got %h expected %h", dv_n[i], p, dv_p[i]);
            else n_pass++;
            n_checks++;
            if (x !== dv_x[i] || s !== dv_s[i])
                $display("FAIL %s_flags: got inexact=%b sat=%b expected inexact=%b sat=%b",
                         dv_n[i], x, s, dv_x[i], dv_s[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random_stream(input int nbeats);
        logic [31:0] ep[$];
        logic        ex[$];
        logic        es[$];
        beat_t       cur;
        logic [31:0] p;
        logic [31:0] hp;
        logic        x;
        logic        s;
        logic        hx;
        logic        hs;
        bit          held;
        bit          acc;
        int          sent;
        int          got;
        int          cyc;
        sent = 0; got = 0; cyc = 0; held = 1'b0; acc = 1'b0;
        hp = '0; hx = 1'b0; hs = 1'b0;
        cur = rand_beat();
        in_valid = 1'b0;
        while (got < nbeats && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin in_valid = 1'b0; acc = 1'b0; end
            if (held) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_posit !== hp || out_inexact !== hx || out_sat !== hs)
                    $display("FAIL stream_hold: got v=%b p=%h x=%b s=%b expected v=1 p=%h x=%b s=%b",
                             out_valid, out_posit, out_inexact, out_sat, hp, hx, hs);
                else n_pass++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < nbeats && $urandom_range(0, 3) != 0) begin
                cur = rand_beat();
                drive(cur);
                in_valid = 1'b1;
            end
            #1;
            if (in_valid && in_ready) begin
                model(cur, p, x, s);
                ep.push_back(p); ex.push_back(x); es.push_back(s);
                sent++;
                acc = 1'b1;
            end
            held = 1'b0;
            if (out_valid && out_ready) begin
                n_checks++;
                if (ep.size() == 0) begin
                    $display("FAIL stream_extra: got beat %h expected no beat", out_posit);
                end else begin
                    p = ep.pop_front(); x = ex.pop_front(); s = es.pop_front();
                    got++;
                    if (out_posit !== p || out_inexact !== x || out_sat !== s)
                        $display("FAIL stream_beat%0d: got p=%h x=%b s=%b expected p=%h x=%b s=%b",
                                 got, out_posit, out_inexact, out_sat, p, x, s);
                    else n_pass++;
                end
            end else if (out_valid) begin
                held = 1'b1; hp = out_posit; hx = out_inexact; hs = out_sat;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != nbeats || ep.size() != 0)
            $display("FAIL stream_count: got %0d beats (%0d pending) expected %0d", got, ep.size(), nbeats);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        beat_t       b[3];
        logic [31:0] p[3];
        logic        x[3];
        logic        s[3];
        for (int i = 0; i < 3; i++) begin
            b[i] = rand_beat();
            b[i].zro = 1'b0; b[i].nr = 1'b0;
            model(b[i], p[i], x[i], s[i]);
        end
        @(negedge clk);
        out_ready = 1'b0;
        drive(b[0]); in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready_a: got %b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
        drive(b[1]);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready_b: got %b expected 1", in_ready);
        else n_pass++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(b[2]);
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_posit !== p[0])
                $display("FAIL b2b_stall%0d: got rdy=%b v=%b p=%h expected rdy=0 v=1 p=%h",
                         c, in_ready, out_valid, out_posit, p[0]);
            else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_release: got %b expected 1", in_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_posit !== p[i] || out_inexact !== x[i] || out_sat !== s[i])
                $display("FAIL b2b_out%0d: got v=%b p=%h x=%b s=%b expected v=1 p=%h x=%b s=%b",
                         i, out_valid, out_posit, out_inexact, out_sat, p[i], x[i], s[i]);
            else n_pass++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drained: got out_valid=%b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_inflight();
        bit stale;
        stale = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        drive(mkb(1'b0, 1'b0, 1'b0, 5, 32'h8000_0001, 1'b1, 1'b0)); in_valid = 1'b1;
        @(negedge clk);
        drive(mkb(1'b1, 1'b0, 1'b0, -7, 32'h0F0F_0F0F, 1'b0, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL rst_precond: got out_valid=%b expected 1", out_valid);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_posit !== '0 || out_sat !== 1'b0 || out_inexact !== 1'b0)
            $display("FAIL rst_async: got v=%b p=%h x=%b s=%b expected all zero",
                     out_valid, out_posit, out_inexact, out_sat);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready);
        else n_pass++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++;
        if (stale) $display("FAIL rst_stale: got stale out_valid=1 expected 0");
        else n_pass++;
`ifdef POSIT_ROUND_STATS_EN
        n_checks++;
        if (stat_cnt !== 16'h0) $display("FAIL rst_stat: got %h expected 0000", stat_cnt);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_stream(300);
        test_back_to_back();
        test_reset_inflight();
        test_random_stream(60);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
